// File: rtl/switch_out_sched_pkg.sv
// Shared definitions for the switch output scheduler: sizes, FSM encoding and weight default.
package switch_out_sched_pkg;

    localparam int unsigned NumPorts      = 4;
    localparam int unsigned CreditWidth   = 4;
    // Weight of 1 for every port degenerates to plain round-robin.
    localparam int unsigned DefaultWeight = 1;

    typedef enum logic [1:0] {
        StIdle,
        StArb,
        StGnt,
        StServe
    } sched_state_e;

endpackage

// File: rtl/switch_out_sched_rr_pick.sv
// Rotating first-one search: returns the first set bit of mask at or after start, with wrap.
// Purely combinational so both the egress scheduler and the ingress side can share it.
module switch_out_sched_rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  onehot,
    output logic          found
);

    logic [IW-1:0] idx;

    // Walk start, start+1, ... (mod N) and keep only the first hit.
    always_comb begin
        onehot = '0;
        found  = 1'b0;
        idx    = start;
        for (int unsigned i = 0; i < N; i++) begin
            idx = IW'((32'(start) + i) % N);
            if (!found && mask[idx]) begin
                onehot[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_out_sched.sv
// Weighted round-robin output scheduler: grants one queue controller per cell slot to the
// read sequencer, spending per-port credits that are refilled from the weights each round.
module switch_out_sched
    import switch_out_sched_pkg::*;
#(
    parameter int unsigned NPORT = NumPorts,
    parameter int unsigned WW    = CreditWidth
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [NPORT-1:0] i_req,
    input  logic             i_cfg_wr,
    input  logic [1:0]       i_cfg_port,
    input  logic [WW-1:0]    i_cfg_weight,
    output logic             o_gnt_vld,
    output logic [NPORT-1:0] o_gnt_sel,
    input  logic             i_gnt_ack,
    input  logic             i_cell_done,
    output logic             o_busy
);

    localparam int unsigned PW = (NPORT > 1) ? $clog2(NPORT) : 1;

    sched_state_e     state_q, state_d;
    logic             gnt_vld_q, gnt_vld_d;
    logic [NPORT-1:0] gnt_sel_q, gnt_sel_d;
    logic             busy_q, busy_d;

    logic [WW-1:0]    weight_q [NPORT];
    logic [WW-1:0]    weight_d [NPORT];
    logic [WW-1:0]    credit_q [NPORT];
    logic [WW-1:0]    credit_d [NPORT];
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;

    logic [NPORT-1:0] active;
    logic [NPORT-1:0] eligible;
    logic [NPORT-1:0] pick_onehot;
    logic             pick_found;
    logic [PW-1:0]    gnt_idx;
    logic             gnt_req;
    logic             do_reload;
    logic             do_take;

    // Config write lands in weight_d so a reload in the same cycle sees the new weight.
    always_comb begin
        weight_d = weight_q;
        if (i_cfg_wr) begin
            weight_d[i_cfg_port] = i_cfg_weight;
        end
    end

    // Active: requesting with a nonzero weight; eligible: active with credit left.
    always_comb begin
        active   = '0;
        eligible = '0;
        for (int unsigned p = 0; p < NPORT; p++) begin
            active[p]   = i_req[p] & (weight_q[p] != '0);
            eligible[p] = active[p] & (credit_q[p] != '0);
        end
    end

    // Encode the latched one-hot grant and track whether its request is still up.
    always_comb begin
        gnt_idx = '0;
        for (int unsigned p = 0; p < NPORT; p++) begin
            if (gnt_sel_q[p]) begin
                gnt_idx = PW'(p);
            end
        end
        gnt_req = |(i_req & gnt_sel_q);
    end

    switch_out_sched_rr_pick #(
        .N  (NPORT),
        .IW (PW)
    ) u_pick (
        .mask   (eligible),
        .start  (rr_ptr_q),
        .onehot (pick_onehot),
        .found  (pick_found)
    );

    // State register; grant and busy outputs are flopped alongside it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            gnt_vld_q <= 1'b0;
            gnt_sel_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_vld_q <= gnt_vld_d;
            gnt_sel_q <= gnt_sel_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (|active) state_d = StArb;
            end
            StArb: begin
                if (pick_found)   state_d = StGnt;
                else if (!active) state_d = StIdle;
                // Otherwise stay for one reload cycle.
            end
            StGnt: begin
                if (i_gnt_ack)     state_d = StServe;
                else if (!gnt_req) state_d = StArb;
            end
            StServe: begin
                if (i_cell_done) state_d = StArb;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output and datapath control decode; ack wins over a same-cycle request drop.
    always_comb begin
        gnt_vld_d = 1'b0;
        gnt_sel_d = gnt_sel_q;
        do_reload = 1'b0;
        do_take   = 1'b0;
        unique case (state_q)
            StArb: begin
                if (pick_found) begin
                    gnt_vld_d = 1'b1;
                    gnt_sel_d = pick_onehot;
                end else if (|active) begin
                    do_reload = 1'b1;
                end
            end
            StGnt: begin
                if (i_gnt_ack) begin
                    do_take = 1'b1;
                end else begin
                    gnt_vld_d = gnt_req;
                end
            end
            default: ;
        endcase
        busy_d = (state_d != StIdle);
    end

    // Credit reload / spend and round-robin pointer update.
    always_comb begin
        credit_d = credit_q;
        rr_ptr_d = rr_ptr_q;
        if (do_reload) begin
            credit_d = weight_d;
        end
        if (do_take) begin
            for (int unsigned p = 0; p < NPORT; p++) begin
                if (gnt_sel_q[p] && (credit_q[p] != '0)) begin
                    credit_d[p] = credit_q[p] - 1'b1;
                end
            end
            // Last credit spent: hand priority to the next port; otherwise keep it here.
            if (credit_q[gnt_idx] == WW'(1)) begin
                rr_ptr_d = (gnt_idx == PW'(NPORT - 1)) ? '0 : gnt_idx + 1'b1;
            end else begin
                rr_ptr_d = gnt_idx;
            end
        end
    end

    // Weight, credit and pointer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned p = 0; p < NPORT; p++) begin
                weight_q[p] <= WW'(DefaultWeight);
                credit_q[p] <= WW'(DefaultWeight);
            end
            rr_ptr_q <= '0;
        end else begin
            weight_q <= weight_d;
            credit_q <= credit_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign o_gnt_vld = gnt_vld_q;
    assign o_gnt_sel = gnt_sel_q;
    assign o_busy    = busy_q;

endmodule
